// File: rtl/display_16hex_rx_pkg.sv
// Shared constants, hex glyph font and frame classification for the 16-hex display bus.
// The display driver uses the same glyph table so the receiver decodes exactly what is sent.
package display_pkg;

    localparam int unsigned DOTS_PER_CHAR = 40;
    localparam int unsigned NUM_CHARS     = 16;
    localparam int unsigned FRAME_DOTS    = 640;
    localparam int unsigned CTRL_BITS     = 32;

    typedef enum logic [2:0] {NONE, DATA, BLANK, CTRL, ERROR} frame_kind_e;

    typedef struct packed {
        logic reset_b;
        logic ce_b;
        logic rs;
        logic data;
        logic clk;
    } disp_pins_t;

    // Five 8-dot columns per glyph; the first column sent sits in the top byte.
    localparam logic [39:0] HEX_GLYPHS [NUM_CHARS] = '{
        40'b00111110_01010001_01001001_01000101_00111110,
        40'b00000000_01000010_01111111_01000000_00000000,
        40'b01100010_01010001_01001001_01001001_01000110,
        40'b00100010_01000001_01001001_01001001_00110110,
        40'b00011000_00010100_00010010_01111111_00010000,
        40'b00100111_01000101_01000101_01000101_00111001,
        40'b00111100_01001010_01001001_01001001_00110000,
        40'b00000001_01110001_00001001_00000101_00000011,
        40'b00110110_01001001_01001001_01001001_00110110,
        40'b00000110_01001001_01001001_00101001_00011110,
        40'b01111110_00001001_00001001_00001001_01111110,
        40'b01111111_01001001_01001001_01001001_00110110,
        40'b00111110_01000001_01000001_01000001_00100010,
        40'b01111111_01000001_01000001_01000001_00111110,
        40'b01111111_01001001_01001001_01001001_01000001,
        40'b01111111_00001001_00001001_00001001_00000001
    };

    function automatic logic [39:0] hex_glyph(input logic [3:0] nibble);
        return HEX_GLYPHS[nibble];
    endfunction

endpackage

// File: rtl/display_16hex_rx_if.sv
// Six-wire serial display bus: the driver owns it (master), the receiver observes it (slave).
interface display_16hex_rx_if;

    logic disp_clock;
    logic disp_data_out;
    logic disp_rs;
    logic disp_ce_b;
    logic disp_reset_b;
    logic disp_blank;

    modport master (
        output disp_clock, disp_data_out, disp_rs, disp_ce_b, disp_reset_b, disp_blank
    );

    modport slave (
        input disp_clock, disp_data_out, disp_rs, disp_ce_b, disp_reset_b, disp_blank
    );

endinterface

// File: rtl/display_16hex_rx_glyph_to_hex.sv
// Combinational reverse font lookup: 40 dots back to a hex nibble.
module glyph_to_hex
    import display_pkg::*;
(
    input  logic [39:0] glyph,
    output logic        hit,
    output logic        blank,
    output logic [3:0]  nibble
);

    always_comb begin
        hit    = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < int'(NUM_CHARS); i++) begin
            if (glyph == HEX_GLYPHS[i]) begin
                hit    = 1'b1;
                nibble = 4'(i);
            end
        end
        blank = (glyph == '0);
    end

endmodule

// File: rtl/display_16hex_rx.sv
// Receiver for the 16-hex display bus: rebuilds the shown 64-bit word and control writes,
// flagging blank and malformed frames.
module display_16hex_rx
    import display_pkg::*;
(
    input  logic               clock_27mhz,
    input  logic               reset,
    display_16hex_rx_if.slave  disp,
    output logic [63:0]        data_out,
    output logic               data_valid,
    output logic [31:0]        control_out,
    output logic               control_valid,
    output logic               blank_frame,
    output logic               frame_error
);

    localparam logic [9:0] FRAME_CNT  = 10'(FRAME_DOTS);
    localparam logic [9:0] CTRL_CNT   = 10'(CTRL_BITS);
    localparam logic [9:0] CNT_MAX    = '1;
    localparam logic [5:0] GLYPH_LAST = 6'(DOTS_PER_CHAR - 1);
    localparam logic [4:0] CHARS_MAX  = 5'(NUM_CHARS);

    disp_pins_t  pins, s1, s2, s3;
    logic        unused_blank;

    logic [39:0] glyph_sr;
    logic [31:0] ctrl_sr;
    logic [63:0] acc;
    logic [9:0]  bit_cnt;
    logic [5:0]  glyph_bits;
    logic [4:0]  chars;
    logic        char_done;
    logic        frame_rs;
    logic        err_flag;
    logic        all_hit;
    logic        all_blank;

    logic        clk_rise, latch, shift_en, cur_rs, frame_clear;
    logic        g_hit, g_blank;
    logic [3:0]  g_nibble;
    frame_kind_e kind;

    assign pins = {disp.disp_reset_b, disp.disp_ce_b, disp.disp_rs, disp.disp_data_out,
                   disp.disp_clock};
    assign unused_blank = disp.disp_blank;

    assign clk_rise    = s2.clk & ~s3.clk;
    assign latch       = s2.ce_b & ~s3.ce_b;
    // A rise coinciding with the latch sees ce_b already high and is dropped here.
    assign shift_en    = clk_rise & ~s2.ce_b & s2.reset_b;
    assign cur_rs      = (bit_cnt == '0) ? s2.rs : frame_rs;
    assign frame_clear = latch | ~s2.reset_b;

    glyph_to_hex u_decode (
        .glyph  (glyph_sr),
        .hit    (g_hit),
        .blank  (g_blank),
        .nibble (g_nibble)
    );

    always_comb begin
        kind = NONE;
        if (latch && s2.reset_b && bit_cnt != '0) begin
            if (err_flag) begin
                kind = ERROR;
            end else if (!frame_rs && bit_cnt == FRAME_CNT) begin
                kind = all_hit ? DATA : (all_blank ? BLANK : ERROR);
            end else if (frame_rs && bit_cnt == CTRL_CNT) begin
                kind = CTRL;
            end else begin
                kind = ERROR;
            end
        end
    end

    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            s1            <= '0;
            s2            <= '0;
            s3            <= '0;
            glyph_sr      <= '0;
            ctrl_sr       <= '0;
            acc           <= '0;
            bit_cnt       <= '0;
            glyph_bits    <= '0;
            chars         <= '0;
            char_done     <= 1'b0;
            frame_rs      <= 1'b0;
            err_flag      <= 1'b0;
            all_hit       <= 1'b1;
            all_blank     <= 1'b1;
            data_out      <= '0;
            control_out   <= '0;
            data_valid    <= 1'b0;
            control_valid <= 1'b0;
            blank_frame   <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            s1 <= pins;
            s2 <= s1;
            s3 <= s2;

            data_valid    <= (kind == DATA);
            blank_frame   <= (kind == BLANK);
            control_valid <= (kind == CTRL);
            frame_error   <= (kind == ERROR);
            if (kind == DATA) data_out <= acc;
            if (kind == CTRL) control_out <= ctrl_sr;

            if (frame_clear) begin
                bit_cnt    <= '0;
                glyph_bits <= '0;
                chars      <= '0;
                char_done  <= 1'b0;
                frame_rs   <= 1'b0;
                err_flag   <= 1'b0;
                acc        <= '0;
                all_hit    <= 1'b1;
                all_blank  <= 1'b1;
            end else begin
                char_done <= 1'b0;
                if (shift_en) begin
                    glyph_sr <= {glyph_sr[38:0], s2.data};
                    ctrl_sr  <= {ctrl_sr[30:0], s2.data};
                    if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 10'd1;
                    if (bit_cnt == '0) frame_rs <= s2.rs;
                    else if (s2.rs != frame_rs) err_flag <= 1'b1;
                    if (cur_rs && bit_cnt >= CTRL_CNT) err_flag <= 1'b1;
                    if (glyph_bits == GLYPH_LAST) begin
                        glyph_bits <= '0;
                        char_done  <= ~cur_rs;
                    end else begin
                        glyph_bits <= glyph_bits + 6'd1;
                    end
                end
                // Decode is consumed one cycle after the 40th dot lands in glyph_sr.
                if (char_done) begin
                    if (g_hit) acc <= {acc[59:0], g_nibble};
                    else all_hit <= 1'b0;
                    if (!g_blank) all_blank <= 1'b0;
                    if (chars == CHARS_MAX) err_flag <= 1'b1;
                    else chars <= chars + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_display_16hex_rx.sv
// Bench for display_16hex_rx: plays the display driver and predicts each latched frame
// from the font table and frame-size rules.
module tb_display_16hex_rx;
    import display_pkg::*;

    logic        clock_27mhz = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] data_out;
    logic        data_valid;
    logic [31:0] control_out;
    logic        control_valid;
    logic        blank_frame;
    logic        frame_error;

    display_16hex_rx_if disp ();

    display_16hex_rx dut (
        .clock_27mhz   (clock_27mhz),
        .reset         (reset),
        .disp          (disp),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .control_out   (control_out),
        .control_valid (control_valid),
        .blank_frame   (blank_frame),
        .frame_error   (frame_error)
    );

    always #5 clock_27mhz = ~clock_27mhz;

    int cyc = 0;
    int n_data = 0, n_blank = 0, n_ctrl = 0, n_err = 0, data_cyc = 0;
    int latch_cyc = 0;
    int n_checks = 0, n_fail = 0;
    logic [63:0] exp_data = '0;
    logic [31:0] exp_ctrl = '0;

    always @(posedge clock_27mhz) cyc <= cyc + 1;

    always @(negedge clock_27mhz) begin
        if (data_valid) begin
            n_data   <= n_data + 1;
            data_cyc <= cyc;
        end
        if (blank_frame) n_blank <= n_blank + 1;
        if (control_valid) n_ctrl <= n_ctrl + 1;
        if (frame_error) n_err <= n_err + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock_27mhz);
    endtask

    // Bits go out MSB-first from v[n-1]; data changes while disp_clock is low.
    task automatic shift_bits(input logic [1023:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            disp.disp_data_out = v[i];
            tick(3);
            disp.disp_clock = 1'b1;
            tick(3);
            disp.disp_clock = 1'b0;
        end
        tick(3);
    endtask

    task automatic do_frame(input logic rs, input logic [1023:0] v, input int n,
                            output logic [15:0] seen);
        int d0, b0, c0, e0;
        #1;
        d0 = n_data; b0 = n_blank; c0 = n_ctrl; e0 = n_err;
        disp.disp_rs   = rs;
        disp.disp_ce_b = 1'b0;
        tick(3);
        shift_bits(v, n);
        disp.disp_ce_b = 1'b1;
        latch_cyc = cyc;
        tick(10);
        #1;
        seen = {4'(n_data - d0), 4'(n_blank - b0), 4'(n_ctrl - c0), 4'(n_err - e0)};
    endtask

    function automatic logic [1023:0] build_dots(input logic [63:0] w);
        logic [1023:0] v = '0;
        for (int c = 0; c < 16; c++) v[639 - 40 * c -: 40] = hex_glyph(w[63 - 4 * c -: 4]);
        return v;
    endfunction

    // Reference: what a latched frame of n bits should mean.
    function automatic frame_kind_e model_frame(input logic rs, input logic [1023:0] v,
                                                input int n, output logic [63:0] val);
        bit ah = 1'b1;
        bit ab = 1'b1;
        bit found;
        logic [39:0] g;
        val = '0;
        if (n == 0) return NONE;
        if (rs) begin
            val = {32'h0, v[31:0]};
            return (n == int'(CTRL_BITS)) ? CTRL : ERROR;
        end
        if (n != int'(FRAME_DOTS)) return ERROR;
        for (int c = 0; c < 16; c++) begin
            g = v[639 - 40 * c -: 40];
            found = 1'b0;
            for (int k = 0; k < 16; k++) begin
                if (g == HEX_GLYPHS[k]) begin
                    found = 1'b1;
                    val[63 - 4 * c -: 4] = 4'(k);
                end
            end
            if (!found) ah = 1'b0;
            if (g != '0) ab = 1'b0;
        end
        if (ah) return DATA;
        if (ab) return BLANK;
        return ERROR;
    endfunction

    function automatic logic [15:0] pulses_for(input frame_kind_e k);
        return {4'(k == DATA), 4'(k == BLANK), 4'(k == CTRL), 4'(k == ERROR)};
    endfunction

    function automatic void apply_model(input frame_kind_e k, input logic [63:0] val);
        if (k == DATA) exp_data = val;
        if (k == CTRL) exp_ctrl = val[31:0];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick(4);
        #1;
        n_checks++;
        if (data_out !== 64'h0 || control_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: data_out=%h control_out=%h, want 0/0", data_out,
                     control_out);
        end
        n_checks++;
        if ({data_valid, blank_frame, control_valid, frame_error} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b want 0000",
                     {data_valid, blank_frame, control_valid, frame_error});
        end
        disp.disp_reset_b = 1'b1;
        reset = 1'b0;
        tick(8);
        #1;
        n_checks++;
        if (n_data + n_blank + n_ctrl + n_err !== 0) begin
            n_fail++;
            $display("FAIL reset_release_pulses: got %0d pulses want 0",
                     n_data + n_blank + n_ctrl + n_err);
        end
    endtask

    task automatic test_boot();
        logic [1023:0] v;
        logic [63:0] val;
        logic [15:0] seen;
        frame_kind_e k;
        v = '0;
        k = model_frame(1'b0, v, 640, val);
        do_frame(1'b0, v, 640, seen);
        apply_model(k, val);
        n_checks++;
        if (seen !== pulses_for(k)) begin
            n_fail++;
            $display("FAIL boot_blank pulses: got %h want %h", seen, pulses_for(k));
        end
        n_checks++;
        if (data_out !== exp_data) begin
            n_fail++;
            $display("FAIL boot_blank data_out: got %h want %h", data_out, exp_data);
        end
        v = '0;
        v[31:0] = 32'h7F7F_7F7F;
        k = model_frame(1'b1, v, 32, val);
        do_frame(1'b1, v, 32, seen);
        apply_model(k, val);
        n_checks++;
        if (seen !== pulses_for(k) || control_out !== exp_ctrl) begin
            n_fail++;
            $display("FAIL boot_ctrl: pulses %h ctrl %h, want %h ctrl %h", seen, control_out,
                     pulses_for(k), exp_ctrl);
        end
        v = build_dots(64'h0123_4567_89AB_CDEF);
        for (int r = 0; r < 2; r++) begin
            k = model_frame(1'b0, v, 640, val);
            do_frame(1'b0, v, 640, seen);
            apply_model(k, val);
            n_checks++;
            if (seen !== pulses_for(k) || data_out !== exp_data) begin
                n_fail++;
                $display("FAIL boot_data%0d: pulses %h data %h, want %h data %h", r, seen,
                         data_out, pulses_for(k), exp_data);
            end
            n_checks++;
            if (data_cyc - latch_cyc !== 3) begin
                n_fail++;
                $display("FAIL boot_latency%0d: got %0d clocks want 3", r, data_cyc - latch_cyc);
            end
        end
    endtask

    task automatic test_random_frames();
        logic [1023:0] v;
        logic [63:0] w, val;
        logic [15:0] seen;
        frame_kind_e k;
        for (int r = 0; r < 4; r++) begin
            w = (r == 0) ? 64'hFFFF_0000_DEAD_BEEF : {$urandom, $urandom};
            v = build_dots(w);
            k = model_frame(1'b0, v, 640, val);
            do_frame(1'b0, v, 640, seen);
            apply_model(k, val);
            n_checks++;
            if (seen !== pulses_for(k) || data_out !== exp_data) begin
                n_fail++;
                $display("FAIL rand_data%0d: pulses %h data %h, want %h data %h", r, seen,
                         data_out, pulses_for(k), exp_data);
            end
        end
        for (int r = 0; r < 2; r++) begin
            v = '0;
            v[31:0] = $urandom;
            k = model_frame(1'b1, v, 32, val);
            do_frame(1'b1, v, 32, seen);
            apply_model(k, val);
            n_checks++;
            if (seen !== pulses_for(k) || control_out !== exp_ctrl) begin
                n_fail++;
                $display("FAIL rand_ctrl%0d: pulses %h ctrl %h, want %h ctrl %h", r, seen,
                         control_out, pulses_for(k), exp_ctrl);
            end
        end
        v = '0;
        for (int i = 0; i < 20; i++) v[32 * i +: 32] = $urandom;
        k = model_frame(1'b0, v, 640, val);
        do_frame(1'b0, v, 640, seen);
        apply_model(k, val);
        n_checks++;
        if (seen !== pulses_for(k) || data_out !== exp_data) begin
            n_fail++;
            $display("FAIL rand_noise: pulses %h data %h, want %h data %h", seen, data_out,
                     pulses_for(k), exp_data);
        end
    endtask

    task automatic test_malformed();
        logic [1023:0] v;
        logic [63:0] val;
        logic [15:0] seen;
        frame_kind_e k;
        v = build_dots({$urandom, $urandom}) >> 1;
        k = model_frame(1'b0, v, 639, val);
        do_frame(1'b0, v, 639, seen);
        apply_model(k, val);
        n_checks++;
        if (seen !== pulses_for(k) || data_out !== exp_data) begin
            n_fail++;
            $display("FAIL short_frame: pulses %h data %h, want %h data %h", seen, data_out,
                     pulses_for(k), exp_data);
        end
        // Char 7 is the ninth glyph sent; its dot 20 lands at v[280 + 20].
        v = build_dots({$urandom, $urandom});
        v[300] = ~v[300];
        k = model_frame(1'b0, v, 640, val);
        do_frame(1'b0, v, 640, seen);
        apply_model(k, val);
        n_checks++;
        if (seen !== pulses_for(k) || data_out !== exp_data) begin
            n_fail++;
            $display("FAIL bad_glyph: pulses %h data %h, want %h data %h", seen, data_out,
                     pulses_for(k), exp_data);
        end
        v = '0;
        v[32:0] = {1'b1, $urandom};
        k = model_frame(1'b1, v, 33, val);
        do_frame(1'b1, v, 33, seen);
        apply_model(k, val);
        n_checks++;
        if (seen !== pulses_for(k) || control_out !== exp_ctrl) begin
            n_fail++;
            $display("FAIL ctrl_33bit: pulses %h ctrl %h, want %h ctrl %h", seen, control_out,
                     pulses_for(k), exp_ctrl);
        end
    endtask

    // use_sys selects the system reset; otherwise the display reset pin aborts the frame.
    task automatic test_abort(input bit use_sys);
        logic [1023:0] v;
        logic [63:0] val;
        logic [15:0] seen;
        frame_kind_e k;
        int total0;
        v = build_dots({$urandom, $urandom});
        #1;
        total0 = n_data + n_blank + n_ctrl + n_err;
        disp.disp_rs   = 1'b0;
        disp.disp_ce_b = 1'b0;
        tick(3);
        shift_bits(v >> 340, 300);
        if (use_sys) begin
            reset = 1'b1;
            tick(3);
            reset = 1'b0;
            exp_data = '0;
            exp_ctrl = '0;
        end else begin
            disp.disp_reset_b = 1'b0;
            tick(6);
            disp.disp_reset_b = 1'b1;
        end
        tick(6);
        disp.disp_ce_b = 1'b1;
        tick(10);
        #1;
        n_checks++;
        if (n_data + n_blank + n_ctrl + n_err !== total0) begin
            n_fail++;
            $display("FAIL abort%0d pulses: got %0d want 0", use_sys,
                     n_data + n_blank + n_ctrl + n_err - total0);
        end
        n_checks++;
        if (data_out !== exp_data || control_out !== exp_ctrl) begin
            n_fail++;
            $display("FAIL abort%0d outputs: data %h ctrl %h, want %h ctrl %h", use_sys,
                     data_out, control_out, exp_data, exp_ctrl);
        end
        k = model_frame(1'b0, v, 640, val);
        do_frame(1'b0, v, 640, seen);
        apply_model(k, val);
        n_checks++;
        if (seen !== pulses_for(k) || data_out !== exp_data) begin
            n_fail++;
            $display("FAIL abort%0d recover: pulses %h data %h, want %h data %h", use_sys, seen,
                     data_out, pulses_for(k), exp_data);
        end
    endtask

    initial begin
        disp.disp_clock    = 1'b0;
        disp.disp_data_out = 1'b0;
        disp.disp_rs       = 1'b0;
        disp.disp_ce_b     = 1'b1;
        disp.disp_reset_b  = 1'b0;
        disp.disp_blank    = 1'b0;
        test_reset();
        test_boot();
        test_random_frames();
        test_malformed();
        test_abort(1'b1);
        test_abort(1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
